// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, the load
// result-source encoding, FSM states and the access legality check.
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

    // Stores have no unsigned variants, so BU/HU encodings are only legal for loads.
    function automatic logic is_legal_access(input logic       is_store,
                                             input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data extender: picks the byte/half lane from the read word and
// sign- or zero-extends it according to funct3.
module lsu_extend
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'b0, shifted[7:0]};
            F3_HU:   data = {16'b0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one req/ready transaction per access,
// stalls the pipeline while it is outstanding and returns extended load data.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memWriteM,
    input  logic [1:0]  resultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] writeDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stallM,
    output logic [31:0] readDataM,
    output logic        errM
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] read_data_q, read_data_d;
    logic        err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic        is_load;
    logic        access;
    logic        legal;
    logic        timeout_hit;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] ext_data;

    // Extension uses the funct3/offset captured at request time, not the live inputs.
    lsu_extend u_extend (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .word    (mem_rdata),
        .data    (ext_data)
    );

    always_comb begin
        is_load     = (resultSrcM == RESULT_SRC_LOAD);
        access      = memWriteM | is_load;
        legal       = is_legal_access(memWriteM, funct3M, ALUResultM[1:0]);
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

        case (funct3M[1:0])
            2'b00: begin
                be_new    = 4'b0001 << ALUResultM[1:0];
                wdata_new = {4{writeDataM[7:0]}};
            end
            2'b01: begin
                be_new    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{writeDataM[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = writeDataM;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        read_data_d = read_data_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;

        case (state_q)
            IDLE: begin
                if (access && legal) begin
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = memWriteM;
                    mem_addr_d  = {ALUResultM[31:2], 2'b00};
                    mem_wdata_d = wdata_new;
                    mem_be_d    = be_new;
                    cnt_d       = '0;
                    funct3_d    = funct3M;
                    addr_lo_d   = ALUResultM[1:0];
                end else if (access) begin
                    state_d     = DONE;
                    err_d       = 1'b1;
                    read_data_d = '0;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = DONE;
                    if (!mem_we_q) begin
                        read_data_d = ext_data;
                    end
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    err_d       = 1'b1;
                    read_data_d = '0;
                end else begin
                    mem_req_d = 1'b1;
                    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            // EX/MEM still holds the finished instruction here, so inputs are ignored.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            read_data_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            read_data_q <= read_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign readDataM = read_data_q;
    assign errM      = err_q;
    assign stallM    = rst & ((state_q == REQ) | ((state_q == IDLE) & access));

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu: loads, stores, misaligned/illegal
// accesses, request timeout and reset in the middle of a transaction.
module tb_mem_stage_lsu;

    localparam logic [1:0] LD    = 2'b01;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic        clk;
    logic        rst;
    logic        memWriteM;
    logic [1:0]  resultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] writeDataM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stallM;
    logic [31:0] readDataM;
    logic        errM;

    int checks = 0;
    int errors = 0;

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .memWriteM  (memWriteM),
        .resultSrcM (resultSrcM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .writeDataM (writeDataM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .stallM     (stallM),
        .readDataM  (readDataM),
        .errM       (errM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, then lets outputs settle.
    task automatic applyStimulus(input logic wr, input logic [1:0] rs, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic rdy, input logic [31:0] rd);
        @(negedge clk);
        memWriteM  = wr;
        resultSrcM = rs;
        funct3M    = f3;
        ALUResultM = addr;
        writeDataM = wd;
        mem_ready  = rdy;
        mem_rdata  = rd;
        #1;
    endtask

    task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] expAddr, input logic [31:0] rdata,
                           input logic [31:0] expData);
        applyStimulus(1'b0, LD, f3, addr, 32'h0, 1'b0, 32'h0);
        checkOutput({tag, "_idle_stall"}, 32'(stallM), 32'd1);
        checkOutput({tag, "_idle_req"}, 32'(mem_req), 32'd0);
        applyStimulus(1'b0, LD, f3, addr, 32'h0, 1'b1, rdata);
        checkOutput({tag, "_req"}, 32'(mem_req), 32'd1);
        checkOutput({tag, "_req_stall"}, 32'(stallM), 32'd1);
        checkOutput({tag, "_req_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_req_addr"}, mem_addr, expAddr);
        applyStimulus(1'b0, LD, f3, addr, 32'h0, 1'b0, 32'h0);
        checkOutput({tag, "_done_stall"}, 32'(stallM), 32'd0);
        checkOutput({tag, "_done_req"}, 32'(mem_req), 32'd0);
        checkOutput({tag, "_done_data"}, readDataM, expData);
        checkOutput({tag, "_done_err"}, 32'(errM), 32'd0);
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput({tag, "_hold_data"}, readDataM, expData);
        checkOutput({tag, "_hold_stall"}, 32'(stallM), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        memWriteM  = 1'b1;
        resultSrcM = 2'b00;
        funct3M    = F3_W;
        ALUResultM = 32'h0000_0100;
        writeDataM = 32'h0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;

        // Reset state, including stallM forced low while an access is presented
        #2;
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_stall", 32'(stallM), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_be", 32'(mem_be), 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkOutput("rst_rdata", readDataM, 32'd0);
        checkOutput("rst_err", 32'(errM), 32'd0);
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("post_rst_req", 32'(mem_req), 32'd0);

        // Loads with ready in the first REQ cycle
        runLoad("lw", F3_W, 32'h0000_0100, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        runLoad("lb", F3_B, 32'h0000_0103, 32'h0000_0100, 32'h80FF_FF00, 32'hFFFF_FF80);
        runLoad("lbu", F3_BU, 32'h0000_0103, 32'h0000_0100, 32'h80FF_FF00, 32'h0000_0080);
        runLoad("lh", F3_H, 32'h0000_0102, 32'h0000_0100, 32'h80FF_FF00, 32'hFFFF_80FF);
        runLoad("lhu", F3_HU, 32'h0000_0100, 32'h0000_0100, 32'h80FF_FF00, 32'h0000_FF00);

        // Timeout: mem_ready never arrives, request held exactly four cycles
        applyStimulus(1'b0, LD, F3_W, 32'h0000_0300, 32'h0, 1'b0, 32'h0);
        checkOutput("to_idle_stall", 32'(stallM), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, LD, F3_W, 32'h0000_0300, 32'h0, 1'b0, 32'h0);
            checkOutput($sformatf("to_req%0d", i), 32'(mem_req), 32'd1);
            checkOutput($sformatf("to_stall%0d", i), 32'(stallM), 32'd1);
            checkOutput($sformatf("to_err%0d", i), 32'(errM), 32'd0);
        end
        applyStimulus(1'b0, LD, F3_W, 32'h0000_0300, 32'h0, 1'b0, 32'h0);
        checkOutput("to_done_req", 32'(mem_req), 32'd0);
        checkOutput("to_done_err", 32'(errM), 32'd1);
        checkOutput("to_done_stall", 32'(stallM), 32'd0);
        checkOutput("to_done_data", readDataM, 32'd0);
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("to_after_err", 32'(errM), 32'd0);

        runLoad("lw2", F3_W, 32'h0000_0108, 32'h0000_0108, 32'h1357_9BDF, 32'h1357_9BDF);

        // SH to upper half
        applyStimulus(1'b1, 2'b00, F3_H, 32'h0000_0202, 32'h1234_ABCD, 1'b0, 32'h0);
        checkOutput("sh_idle_stall", 32'(stallM), 32'd1);
        applyStimulus(1'b1, 2'b00, F3_H, 32'h0000_0202, 32'h1234_ABCD, 1'b1, 32'h0);
        checkOutput("sh_req", 32'(mem_req), 32'd1);
        checkOutput("sh_we", 32'(mem_we), 32'd1);
        checkOutput("sh_be", 32'(mem_be), 32'hC);
        checkOutput("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        checkOutput("sh_addr", mem_addr, 32'h0000_0200);
        applyStimulus(1'b1, 2'b00, F3_H, 32'h0000_0202, 32'h1234_ABCD, 1'b0, 32'h0);
        checkOutput("sh_done_stall", 32'(stallM), 32'd0);
        checkOutput("sh_done_req", 32'(mem_req), 32'd0);
        checkOutput("sh_keeps_rdata", readDataM, 32'h1357_9BDF);

        // SB to lane 1
        applyStimulus(1'b1, 2'b00, F3_B, 32'h0000_0201, 32'h0000_00EF, 1'b0, 32'h0);
        applyStimulus(1'b1, 2'b00, F3_B, 32'h0000_0201, 32'h0000_00EF, 1'b1, 32'h0);
        checkOutput("sb_be", 32'(mem_be), 32'h2);
        checkOutput("sb_wdata", mem_wdata, 32'hEFEF_EFEF);
        applyStimulus(1'b1, 2'b00, F3_B, 32'h0000_0201, 32'h0000_00EF, 1'b0, 32'h0);
        checkOutput("sb_done_req", 32'(mem_req), 32'd0);

        // SW with ready arriving in the third REQ cycle; outputs must hold
        applyStimulus(1'b1, 2'b00, F3_W, 32'h0000_0204, 32'hCAFE_F00D, 1'b0, 32'h0);
        applyStimulus(1'b1, 2'b00, F3_W, 32'h0000_0204, 32'hCAFE_F00D, 1'b0, 32'h0);
        checkOutput("sw_req1", 32'(mem_req), 32'd1);
        checkOutput("sw_be", 32'(mem_be), 32'hF);
        checkOutput("sw_wdata", mem_wdata, 32'hCAFE_F00D);
        applyStimulus(1'b1, 2'b00, F3_W, 32'h0000_0204, 32'hCAFE_F00D, 1'b0, 32'h0);
        checkOutput("sw_req2", 32'(mem_req), 32'd1);
        checkOutput("sw_addr_hold", mem_addr, 32'h0000_0204);
        applyStimulus(1'b1, 2'b00, F3_W, 32'h0000_0204, 32'hCAFE_F00D, 1'b1, 32'h0);
        checkOutput("sw_req3", 32'(mem_req), 32'd1);
        checkOutput("sw_stall3", 32'(stallM), 32'd1);
        applyStimulus(1'b1, 2'b00, F3_W, 32'h0000_0204, 32'hCAFE_F00D, 1'b0, 32'h0);
        checkOutput("sw_done_req", 32'(mem_req), 32'd0);
        checkOutput("sw_done_stall", 32'(stallM), 32'd0);

        // mem_ready while idle is ignored
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        checkOutput("idle_ready_req", 32'(mem_req), 32'd0);
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("idle_ready_data", readDataM, 32'h1357_9BDF);
        checkOutput("idle_ready_stall", 32'(stallM), 32'd0);

        // Misaligned LW: one stall cycle, error pulse, no request
        applyStimulus(1'b0, LD, F3_W, 32'h0000_0101, 32'h0, 1'b0, 32'h0);
        checkOutput("mis_stall", 32'(stallM), 32'd1);
        checkOutput("mis_req", 32'(mem_req), 32'd0);
        applyStimulus(1'b0, LD, F3_W, 32'h0000_0101, 32'h0, 1'b0, 32'h0);
        checkOutput("mis_err", 32'(errM), 32'd1);
        checkOutput("mis_done_req", 32'(mem_req), 32'd0);
        checkOutput("mis_done_stall", 32'(stallM), 32'd0);
        checkOutput("mis_data", readDataM, 32'd0);
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("mis_err_once", 32'(errM), 32'd0);

        // Store with unsigned funct3 is illegal
        applyStimulus(1'b1, 2'b00, F3_BU, 32'h0000_0200, 32'h55, 1'b0, 32'h0);
        checkOutput("ill_stall", 32'(stallM), 32'd1);
        applyStimulus(1'b1, 2'b00, F3_BU, 32'h0000_0200, 32'h55, 1'b0, 32'h0);
        checkOutput("ill_err", 32'(errM), 32'd1);
        checkOutput("ill_req", 32'(mem_req), 32'd0);
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("ill_err_once", 32'(errM), 32'd0);

        // Reset asserted while a request is outstanding
        applyStimulus(1'b0, LD, F3_W, 32'h0000_0400, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, LD, F3_W, 32'h0000_0400, 32'h0, 1'b0, 32'h0);
        checkOutput("mid_req_before", 32'(mem_req), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mid_req_async", 32'(mem_req), 32'd0);
        checkOutput("mid_stall_async", 32'(stallM), 32'd0);
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b1, 32'h0);
        checkOutput("after_rst_req", 32'(mem_req), 32'd0);
        checkOutput("after_rst_stall", 32'(stallM), 32'd0);
        applyStimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("after_rst_req2", 32'(mem_req), 32'd0);
        runLoad("lw_after_rst", F3_W, 32'h0000_0500, 32'h0000_0500, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
